// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared types and constants for the trapped-I/O capture block.
//   trap_entry_t  : one captured bus cycle {dir, addr, data}, dir=1 for writes
//   trap_state_t  : capture FSM states
//   SEL_*         : hypervisor read sub-addresses (host_sel)
//   EMPTY_READ    : value returned on entry reads while the FIFO is empty
// -----------------------------------------------------------------------------
package trap_pkg;

  localparam int ENTRY_W = 17;

  typedef struct packed {
    logic       dir;   // 1 = guest write (OUT), 0 = guest read (IN)
    logic [7:0] addr;
    logic [7:0] data;
  } trap_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_PUSH     = 2'd2,
    ST_WAIT_END = 2'd3
  } trap_state_t;

  localparam logic [1:0] SEL_STATUS = 2'd0;
  localparam logic [1:0] SEL_ADDR   = 2'd1;
  localparam logic [1:0] SEL_DATA   = 2'd2;
  localparam logic [1:0] SEL_POP    = 2'd3;

  localparam logic [7:0] EMPTY_READ = 8'hFF;

  // Build an entry from the sampled bus; guest reads record data as zero since
  // the data bus is not driven by the guest during an IN cycle.
  function automatic trap_entry_t make_entry(input logic       is_wr,
                                             input logic [7:0] a,
                                             input logic [7:0] d);
    trap_entry_t e;
    e.dir  = is_wr;
    e.addr = a;
    e.data = is_wr ? d : 8'h00;
    return e;
  endfunction

endpackage

// File: rtl/trap_fifo_mem.sv
// -----------------------------------------------------------------------------
// trap_fifo_mem
// DEPTH x 17-bit circular buffer holding captured bus cycles.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   push, pop     : requests; a pop on empty is ignored, a push on full is
//                   dropped unless a pop is accepted on the same clock
//   wr_entry      : entry written on an accepted push
//   head          : oldest entry (stale when empty; caller masks it)
//   count         : valid entries, 0..DEPTH
//   count_next    : value count takes at the next clock edge
//   full, empty   : occupancy flags
//   dropped       : push rejected this clock because the buffer is full
// DEPTH must be a power of two (2..8) so the pointers wrap by overflow.
// -----------------------------------------------------------------------------
module trap_fifo_mem
  import trap_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  trap_entry_t wr_entry,
  output trap_entry_t head,
  output logic [3:0]  count,
  output logic [3:0]  count_next,
  output logic        full,
  output logic        empty,
  output logic        dropped
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  trap_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == 4'd0);
  assign pop_ok  = pop && !empty;
  // A pop on the same clock frees the slot, so a full buffer still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && !push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only visible through
  // rd_ptr/count, which are reset, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/trap_capture.sv
// -----------------------------------------------------------------------------
// trap_capture
// Records trapped Z80 I/O cycles (port, direction, write data) into a small
// FIFO which the hypervisor drains through the mapper I/O window.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   capture               : capture_address from the mode logic; arms a capture
//   iorq_n, rd_n, wr_n    : raw Z80 strobes
//   addr, data_in         : Z80 A7..A0 and data bus
//   host_sel, host_rd_en  : hypervisor read sub-address and read strobe
//   data_out, data_oe     : hypervisor read data and its drive enable
//   count                 : valid entries
//   overflow              : sticky, an entry was dropped
//   fifo_irq_n            : low while entries are pending (only when
//                           TRAP_CAPTURE_IRQ_EN is defined, else tied high)
// Configuration macro: TRAP_CAPTURE_IRQ_EN
// -----------------------------------------------------------------------------
module trap_capture
  import trap_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       capture,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic [1:0] host_sel,
  input  logic       host_rd_en,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [3:0] count,
  output logic       overflow,
  output logic       fifo_irq_n
);

  trap_state_t state_q, state_d;
  trap_entry_t entry_q, entry_d;
  trap_entry_t head;
  logic        strobe, strobe_q, strobe_d;
  logic        qualified;
  logic        latch_en, push;
  logic        host_rd_q, host_rd_d;
  logic        host_fall, pop, status_clr;
  logic        overflow_q, overflow_d;
  logic [3:0]  count_next;
  logic        full, empty, dropped;

  // An I/O cycle in progress in either direction.
  assign strobe    = !iorq_n && (!rd_n || !wr_n);
  // Two consecutive low samples filter single-clock glitches on the strobes.
  assign qualified = strobe && strobe_q;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (capture) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!capture)       state_d = ST_IDLE;
        else if (qualified) state_d = ST_PUSH;
      end
      ST_PUSH:     state_d = ST_WAIT_END;
      // Hold until the bus cycle ends so a long strobe yields one entry.
      ST_WAIT_END: if (iorq_n) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    latch_en = 1'b0;
    push     = 1'b0;
    case (state_q)
      ST_ARMED: latch_en = capture && qualified;
      ST_PUSH:  push     = 1'b1;
      default: begin
        latch_en = 1'b0;
        push     = 1'b0;
      end
    endcase
  end

  // ---- Datapath next-state ----
  always_comb begin
    strobe_d  = strobe;
    host_rd_d = host_rd_en;
    entry_d   = entry_q;
    if (latch_en) entry_d = make_entry(!wr_n, addr, data_in);

    overflow_d = overflow_q;
    if (dropped)         overflow_d = 1'b1;   // a drop wins over a clearing read
    else if (status_clr) overflow_d = 1'b0;
  end

  // Host read completes on the registered falling edge of host_rd_en.
  assign host_fall  = host_rd_q && !host_rd_en;
  assign pop        = host_fall && (host_sel == SEL_POP);
  assign status_clr = host_fall && (host_sel == SEL_STATUS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strobe_q   <= 1'b0;
      host_rd_q  <= 1'b0;
      entry_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q   <= strobe_d;
      host_rd_q  <= host_rd_d;
      entry_q    <= entry_d;
      overflow_q <= overflow_d;
    end
  end

  trap_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .wr_entry   (entry_q),
    .head       (head),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty),
    .dropped    (dropped)
  );

  // ---- Host read mux ----
  always_comb begin
    data_out = 8'h00;
    if (host_rd_en) begin
      case (host_sel)
        SEL_STATUS: data_out = {overflow_q, empty, 2'b00, count};
        SEL_ADDR:   data_out = empty ? EMPTY_READ : head.addr;
        SEL_DATA:   data_out = empty ? EMPTY_READ : head.data;
        SEL_POP:    data_out = empty ? EMPTY_READ : {head.dir, 7'b0};
        default:    data_out = 8'h00;
      endcase
    end
  end

  assign data_oe  = host_rd_en;
  assign overflow = overflow_q;

`ifdef TRAP_CAPTURE_IRQ_EN
  logic irq_n_q, irq_n_d;
  logic unused_full;

  // Registered from the next count so the flag moves on the same edge as count.
  assign irq_n_d     = (count_next == 4'd0);
  assign unused_full = full;

  always_ff @(posedge clk) begin
    if (!reset_n) irq_n_q <= 1'b1;
    else          irq_n_q <= irq_n_d;
  end

  assign fifo_irq_n = irq_n_q;
`else
  logic unused_fifo;
  assign unused_fifo = ^{count_next, full};
  assign fifo_irq_n  = 1'b1;
`endif

endmodule

// File: tb/tb_trap_capture.sv
// -----------------------------------------------------------------------------
// tb_trap_capture
// Directed self-checking bench for trap_capture (DEPTH=4).
// -----------------------------------------------------------------------------
module tb_trap_capture;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       capture;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] addr, data_in;
  logic [1:0] host_sel;
  logic       host_rd_en;
  logic [7:0] data_out;
  logic       data_oe;
  logic [3:0] count;
  logic       overflow;
  logic       fifo_irq_n;

  int checks   = 0;
  int failures = 0;

  trap_capture #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture    (capture),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .addr       (addr),
    .data_in    (data_in),
    .host_sel   (host_sel),
    .host_rd_en (host_rd_en),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .count      (count),
    .overflow   (overflow),
    .fifo_irq_n (fifo_irq_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic exp_irq(input int cnt);
`ifdef TRAP_CAPTURE_IRQ_EN
    return (cnt == 0);
`else
    return 1'b1;
`endif
  endfunction

  // Advance n rising edges and settle 2 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic release_bus();
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
  endtask

  task automatic drive_strobe(input logic is_wr, input logic [7:0] a,
                              input logic [7:0] d);
    iorq_n  = 1'b0;
    addr    = a;
    data_in = d;
    if (is_wr) wr_n = 1'b0;
    else       rd_n = 1'b0;
  endtask

  // Arm, hold the strobe low for 'low' clocks, then end the cycle.
  task automatic bus_cycle(input logic is_wr, input logic [7:0] a,
                           input logic [7:0] d, input int low);
    capture = 1'b1;
    step(1);
    drive_strobe(is_wr, a, d);
    step(low);
    release_bus();
    capture = 1'b0;
    step(2);
  endtask

  // One complete hypervisor read; the falling edge of host_rd_en is seen
  // on the second edge, which is where pops and overflow clears happen.
  task automatic host_read(input logic [1:0] sel, input logic [7:0] exp,
                           input string tag);
    host_sel   = sel;
    host_rd_en = 1'b1;
    #1;
    check(tag, data_out, exp);
    step(1);
    host_rd_en = 1'b0;
    step(1);
  endtask

  logic [7:0] exp_addr [4];
  logic [7:0] exp_data [4];

  initial begin
    reset_n    = 1'b0;
    capture    = 1'b0;
    release_bus();
    addr       = 8'h00;
    data_in    = 8'h00;
    host_sel   = 2'd0;
    host_rd_en = 1'b0;

    // ---- reset state ----
    step(2);
    check("rst_count", count, 4'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_irq", fifo_irq_n, 1'b1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_oe", data_oe, 1'b0);
    reset_n = 1'b1;
    step(1);

    // ---- guest OUT (0x41),0x5A with latency checks ----
    capture = 1'b1;
    step(1);                            // IDLE -> ARMED
    drive_strobe(1'b1, 8'h41, 8'h5A);
    step(1);                            // clock N: first low sample
    check("out_cnt_N", count, 4'd0);
    step(1);                            // clock N+1: qualify and latch
    check("out_cnt_N1", count, 4'd0);
    step(1);                            // clock N+2: push
    check("out_cnt_N2", count, 4'd1);
    check("out_irq", fifo_irq_n, exp_irq(1));
    release_bus();
    capture = 1'b0;
    step(2);
    host_read(2'd0, 8'h01, "out_status");
    host_sel   = 2'd1;
    host_rd_en = 1'b1;
    #1;
    check("out_data_oe", data_oe, 1'b1);
    host_rd_en = 1'b0;
    step(1);
    host_read(2'd1, 8'h41, "out_sel1");
    host_read(2'd2, 8'h5A, "out_sel2");
    check("out_cnt_before_pop", count, 4'd1);
    host_read(2'd3, 8'h80, "out_sel3");
    check("out_cnt_after_pop", count, 4'd0);
    check("out_irq_after_pop", fifo_irq_n, exp_irq(0));

    // ---- guest IN (0x10), strobe held 6 clocks ----
    bus_cycle(1'b0, 8'h10, 8'hC3, 6);
    check("in_count", count, 4'd1);
    host_read(2'd1, 8'h10, "in_sel1");
    host_read(2'd2, 8'h00, "in_sel2");
    host_read(2'd3, 8'h00, "in_sel3");
    check("in_cnt_after_pop", count, 4'd0);

    // ---- DEPTH+1 writes: overflow, oldest entries kept ----
    for (int i = 0; i < DEPTH + 1; i++)
      bus_cycle(1'b1, 8'h20 + 8'(i), 8'hA0 + 8'(i), 2);
    check("ovf_count", count, 4'd4);
    check("ovf_flag", overflow, 1'b1);
    host_read(2'd0, 8'h84, "ovf_status");
    check("ovf_cleared", overflow, 1'b0);
    host_read(2'd0, 8'h04, "ovf_status2");

    // ---- full FIFO: push and pop on the same clock ----
    capture = 1'b1;
    step(1);                            // ARMED
    drive_strobe(1'b1, 8'h30, 8'h5C);
    host_sel   = 2'd3;
    host_rd_en = 1'b1;
    step(1);                            // N
    step(1);                            // N+1: latch; host_rd registered high
    host_rd_en = 1'b0;
    release_bus();
    capture = 1'b0;
    step(1);                            // N+2: push and pop together
    check("pp_count", count, 4'd4);
    check("pp_overflow", overflow, 1'b0);
    step(1);
    exp_addr = '{8'h21, 8'h22, 8'h23, 8'h30};
    exp_data = '{8'hA1, 8'hA2, 8'hA3, 8'h5C};
    for (int i = 0; i < 4; i++) begin
      host_read(2'd1, exp_addr[i], $sformatf("drain_addr%0d", i));
      host_read(2'd2, exp_data[i], $sformatf("drain_data%0d", i));
      host_read(2'd3, 8'h80, $sformatf("drain_dir%0d", i));
    end
    check("drain_count", count, 4'd0);

    // ---- no entry: 1-clock strobe, capture dropped early ----
    bus_cycle(1'b1, 8'h55, 8'h66, 1);
    check("pulse_count", count, 4'd0);
    capture = 1'b1;
    step(1);
    drive_strobe(1'b1, 8'h77, 8'h88);
    capture = 1'b0;
    step(3);
    release_bus();
    step(2);
    check("abort_count", count, 4'd0);
    host_read(2'd1, 8'hFF, "empty_sel1");
    host_read(2'd2, 8'hFF, "empty_sel2");
    host_read(2'd3, 8'hFF, "empty_sel3");
    host_read(2'd0, 8'h40, "empty_status");
    check("empty_pop_count", count, 4'd0);

    // ---- reset while ARMED with 2 entries ----
    bus_cycle(1'b1, 8'h01, 8'h02, 2);
    bus_cycle(1'b0, 8'h03, 8'h04, 2);
    check("rst2_pre_count", count, 4'd2);
    capture = 1'b1;
    step(1);                            // ARMED
    reset_n = 1'b0;
    capture = 1'b0;
    step(1);
    check("rst2_count", count, 4'd0);
    check("rst2_irq", fifo_irq_n, 1'b1);
    reset_n = 1'b1;
    drive_strobe(1'b1, 8'h99, 8'hAA);   // FSM must be IDLE: nothing captured
    step(3);
    release_bus();
    step(2);
    check("rst2_idle_count", count, 4'd0);
    host_read(2'd0, 8'h40, "rst2_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
